// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Purpose
//   Multi-cycle front end for the ALU and its opcode decoder. The block accepts
//   one command at a time and drives the ALU operand/opcode registers. It then
//   captures the combinational ALU result and returns it over a response
//   handshake.
//   - Shift opcodes (3'b010, 3'b011, 3'b100) are executed as SHAMT one-bit ALU
//     passes. Each pass feeds its result back as operand A.
//   - Every other legal opcode takes exactly one ALU pass.
//   - Opcode 3'b111 is illegal. It is answered with rsp_err=1 and
//     rsp_result=0, and the ALU is never issued.
//
// Handshakes (both sides)
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   - Once valid is raised, the producer holds valid and its payload stable
//     until that edge.
//   - req_ready is 1 only while idle.
//   - rsp_valid/rsp_result/rsp_err (and the flags) stay stable until the
//     response transfer.
//   - After a response transfer, req_ready returns one cycle later. There is no
//     same-cycle turnaround.
//
// Parameters
//   WIDTH   datapath width of operands and result
//   SW      width of the shift count
//
// Ports
//   clk         in   clock; all state changes on the rising edge
//   reset       in   asynchronous, active-high reset; aborts any command
//   req_valid   in   command valid
//   req_ready   out  sequencer can accept a command (registered)
//   req_op      in   [2:0]      ALU opcode
//   req_a       in   [WIDTH-1:0] operand A
//   req_b       in   [WIDTH-1:0] operand B
//   req_shamt   in   [SW-1:0]   shift count; only used for shift opcodes
//   alu_en      out  alu_op/alu_a/alu_b valid this cycle
//   alu_op      out  [2:0]      opcode to the ALU decoder
//   alu_a       out  [WIDTH-1:0] ALU operand A
//   alu_b       out  [WIDTH-1:0] ALU operand B
//   alu_result  in   [WIDTH-1:0] combinational ALU output; sampled while alu_en
//   rsp_valid   out  response valid
//   rsp_ready   in   consumer accepts the response
//   rsp_result  out  [WIDTH-1:0] final result
//   rsp_err     out  illegal opcode
//   rsp_zero    out  (ALU_SEQ_FLAGS_EN only) rsp_result == 0, forced 0 on error
//   rsp_neg     out  (ALU_SEQ_FLAGS_EN only) rsp_result MSB, forced 0 on error
//   dbg_state   out  [1:0] current FSM state, for observation only
//
// Configuration
//   ALU_SEQ_FLAGS_EN  define to add the rsp_zero / rsp_neg response flags.
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [SW-1:0]    req_shamt,
    output logic             alu_en,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
`ifdef ALU_SEQ_FLAGS_EN
    output logic             rsp_zero,
    output logic             rsp_neg,
`endif
    output logic [1:0]       dbg_state
);

    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_SHIFT = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        state;
    logic [SW-1:0] cnt;        // remaining shift passes, including the current one

    // Response load: one place decides when and what the response registers
    // take, so the optional flags stay in lock-step with rsp_result.
    logic             rsp_load;
    logic [WIDTH-1:0] rsp_next;
    logic             err_next;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == 3'b010) || (op == 3'b011) || (op == 3'b100);
    endfunction

    assign dbg_state = state;

    always_comb begin
        rsp_load = 1'b0;
        rsp_next = alu_result;
        err_next = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_op == OP_ILLEGAL) begin
                        rsp_load = 1'b1;
                        rsp_next = '0;
                        err_next = 1'b1;
                    end else if (is_shift(req_op) && (req_shamt == '0)) begin
                        // Zero-length shift: A passes straight through, no ALU pass.
                        rsp_load = 1'b1;
                        rsp_next = req_a;
                    end
                end
            end
            S_ISSUE: rsp_load = 1'b1;
            S_SHIFT: rsp_load = (cnt == SW'(1));
            default: rsp_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            alu_en     <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (rsp_load) begin
                rsp_valid  <= 1'b1;
                rsp_result <= rsp_next;
                rsp_err    <= err_next;
            end

            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (rsp_load) begin
                            // Illegal op or zero shift: answered without touching
                            // the ALU registers, which keep their last values.
                            state <= S_RESP;
                        end else begin
                            alu_en <= 1'b1;
                            alu_op <= req_op;
                            alu_a  <= req_a;
                            alu_b  <= req_b;
                            cnt    <= req_shamt;
                            state  <= is_shift(req_op) ? S_SHIFT : S_ISSUE;
                        end
                    end else begin
                        // Also covers the first cycle after reset release.
                        req_ready <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    alu_en <= 1'b0;
                    state  <= S_RESP;
                end

                S_SHIFT: begin
                    if (cnt == SW'(1)) begin
                        alu_en <= 1'b0;
                        state  <= S_RESP;
                    end else begin
                        // Feed the one-bit pass result back for the next pass.
                        alu_a <= alu_result;
                        cnt   <= cnt - SW'(1);
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_zero <= 1'b0;
            rsp_neg  <= 1'b0;
        end else if (rsp_load) begin
            rsp_zero <= !err_next && (rsp_next == '0);
            rsp_neg  <= !err_next && rsp_next[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Directed bench for alu_op_sequencer. The bench supplies a small combinational
// ALU. A command-level model predicts the following from the accepted command:
// - when req_ready, alu_en and rsp_valid must be high;
// - which operands each ALU pass must carry;
// - the final response.
// The model works from whole shifts and plain arithmetic. One negedge process
// compares the DUT against the model every cycle. Literal expectations pin the
// model on the main scenarios.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int W  = 32;
    localparam int SW = $clog2(W);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          req_valid, req_ready;
    logic [2:0]    req_op;
    logic [W-1:0]  req_a, req_b;
    logic [SW-1:0] req_shamt;
    logic          alu_en;
    logic [2:0]    alu_op;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_err;
    logic [1:0]    dbg_state;
`ifdef ALU_SEQ_FLAGS_EN
    logic          rsp_zero, rsp_neg;
`endif

    alu_op_sequencer #(.WIDTH(W), .SW(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_shamt  (req_shamt),
        .alu_en     (alu_en),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
`ifdef ALU_SEQ_FLAGS_EN
        .rsp_zero   (rsp_zero),
        .rsp_neg    (rsp_neg),
`endif
        .dbg_state  (dbg_state)
    );

    // ---------------- ALU (one-bit shifts per pass) ----------------
    function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return {a[W-2:0], 1'b0};
            3'b011:  return {1'b0, a[W-1:1]};
            3'b100:  return {a[W-1], a[W-1:1]};
            3'b101:  return a & b;
            3'b110:  return a | b;
            default: return '0;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

    // ---------------- model ----------------
    function automatic logic [W-1:0] model_shift(input logic [2:0] op, input logic [W-1:0] a,
                                                 input int n);
        logic signed [W-1:0] s;
        s = a;
        case (op)
            3'b010:  return a << n;
            3'b011:  return a >> n;
            default: return s >>> n;
        endcase
    endfunction

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == 3'b010) || (op == 3'b011) || (op == 3'b100);
    endfunction

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           cyc = 0;
    int           since_rst = 0;
    logic         pending = 1'b0;
    logic [2:0]   m_op;
    logic [W-1:0] m_a, m_b;
    logic         m_err, m_shift;
    int           m_passes, m_acc = 0;
    logic         rsp_seen;
    int           lat_seen;
    int           cmd_en_count = 0;
    logic [W-1:0] a_seq[8];
    int           rsp_count = 0, hs_cyc = 0;
    logic [W-1:0] last_result;
    logic         last_err;
    int           last_en_count, last_lat;
    logic [2:0]   prev_op;
    logic [W-1:0] prev_a, prev_b;

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic exp_ready, exp_rv, exp_en;
        int   idx;
        cyc++;
        if (reset) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_alu_en", alu_en, 0);
            check("rst_alu_op", alu_op, 0);
            check("rst_alu_a", alu_a, 0);
            check("rst_alu_b", alu_b, 0);
            check("rst_rsp_result", rsp_result, 0);
            check("rst_rsp_err", rsp_err, 0);
`ifdef ALU_SEQ_FLAGS_EN
            check("rst_rsp_zero", rsp_zero, 0);
            check("rst_rsp_neg", rsp_neg, 0);
`endif
            pending   = 1'b0;
            exp_q.delete();
            since_rst = 0;
        end else begin
            exp_ready = !pending && (since_rst >= 1);
            exp_rv    = pending && (cyc >= m_acc + m_passes + 1);
            exp_en    = pending && (cyc >= m_acc + 1) && (cyc <= m_acc + m_passes);
            check("req_ready", req_ready, exp_ready);
            check("rsp_valid", rsp_valid, exp_rv);
            check("alu_en", alu_en, exp_en);

            if (alu_en) begin
                if (cmd_en_count < 8) a_seq[cmd_en_count] = alu_a;
                cmd_en_count++;
                if (exp_en) begin
                    idx = cyc - m_acc - 1;
                    check("alu_op", alu_op, m_op);
                    check("alu_a", alu_a, m_shift ? model_shift(m_op, m_a, idx) : m_a);
                    check("alu_b", alu_b, m_b);
                end
            end else begin
                check("alu_hold_op", alu_op, prev_op);
                check("alu_hold_a", alu_a, prev_a);
                check("alu_hold_b", alu_b, prev_b);
            end

            if (exp_rv && rsp_valid) begin
                check("rsp_result", rsp_result, exp_q[0]);
                check("rsp_err", rsp_err, m_err);
`ifdef ALU_SEQ_FLAGS_EN
                check("rsp_zero", rsp_zero, !m_err && (exp_q[0] == '0));
                check("rsp_neg", rsp_neg, !m_err && exp_q[0][W-1]);
`endif
                if (!rsp_seen) begin
                    lat_seen = cyc - m_acc;
                    rsp_seen = 1'b1;
                end
                if (rsp_ready) begin
                    last_result   = rsp_result;
                    last_err      = rsp_err;
                    last_en_count = cmd_en_count;
                    last_lat      = lat_seen;
                    hs_cyc        = cyc;
                    rsp_count++;
                    void'(exp_q.pop_front());
                    pending = 1'b0;
                end
            end

            if (req_valid && req_ready && !pending) begin
                m_op     = req_op;
                m_a      = req_a;
                m_b      = req_b;
                m_err    = (req_op == 3'b111);
                m_shift  = is_shift_op(req_op);
                m_passes = m_err ? 0 : (m_shift ? int'(req_shamt) : 1);
                m_acc    = cyc;
                rsp_seen = 1'b0;
                cmd_en_count = 0;
                if (m_err)        exp_q.push_back('0);
                else if (m_shift) exp_q.push_back(model_shift(req_op, req_a, int'(req_shamt)));
                else              exp_q.push_back(alu_fn(req_op, req_a, req_b));
                pending = 1'b1;
            end
            since_rst++;
        end
        prev_op = alu_op;
        prev_a  = alu_a;
        prev_b  = alu_b;
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [SW-1:0] sh);
        int n;
        req_op = op; req_a = a; req_b = b; req_shamt = sh; req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) check("accept_timeout", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_count < target && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (rsp_count < target) check("rsp_timeout", rsp_count, target);
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [SW-1:0] sh);
        int target;
        target = rsp_count + 1;
        send_cmd(op, a, b, sh);
        wait_rsp(target);
    endtask

    // ---------------- directed table ----------------
    logic [2:0]    t_op  [9] = '{3'd0, 3'd1, 3'd5, 3'd6, 3'd2, 3'd3, 3'd4, 3'd4, 3'd1};
    logic [W-1:0]  t_a   [9] = '{32'hFFFF_FFFF, 32'd3, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'd1,
                                 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd5};
    logic [W-1:0]  t_b   [9] = '{32'd1, 32'd10, 32'h3C3C_3C3C, 32'h0F0F_0000, 32'd0,
                                 32'd0, 32'd0, 32'd0, 32'd5};
    logic [SW-1:0] t_sh  [9] = '{5'd9, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd31, 5'd3, 5'd0};
    logic [W-1:0]  t_exp [9] = '{32'h0000_0000, 32'hFFFF_FFF9, 32'h3030_3030, 32'hFFFF_F0F0,
                                 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0800_0000,
                                 32'h0000_0000};

    // ---------------- main sequence ----------------
    initial begin
        int n, hs_before, hs_first;
        reset = 1'b1;
        req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_shamt = '0;
        rsp_ready = 1'b1;

        // Reset for 3 cycles, then release.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_held", req_ready, 0);
        reset = 1'b0;
        #1;
        check("ready_at_release", req_ready, 0);
        @(posedge clk);
        #1;
        check("ready_after_release", req_ready, 1);

        // Single-pass add.
        run_cmd(3'b000, 32'd5, 32'd7, '0);
        check("add_result", last_result, 32'd12);
        check("add_en_count", last_en_count, 1);
        check("add_latency", last_lat, 2);

        // Shift left by 4: four one-bit passes.
        run_cmd(3'b010, 32'h1, 32'd0, 5'd4);
        check("shl_result", last_result, 32'd16);
        check("shl_en_count", last_en_count, 4);
        check("shl_latency", last_lat, 5);
        check("shl_a0", a_seq[0], 32'd1);
        check("shl_a1", a_seq[1], 32'd2);
        check("shl_a2", a_seq[2], 32'd4);
        check("shl_a3", a_seq[3], 32'd8);

        // Zero-length shift and illegal opcode.
        run_cmd(3'b011, 32'hDEAD, 32'd0, '0);
        check("shz_result", last_result, 32'hDEAD);
        check("shz_en_count", last_en_count, 0);
        check("shz_err", last_err, 0);
        run_cmd(3'b111, 32'd123, 32'd456, 5'd3);
        check("ill_err", last_err, 1);
        check("ill_result", last_result, 0);
        check("ill_en_count", last_en_count, 0);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            run_cmd(t_op[i], t_a[i], t_b[i], t_sh[i]);
            check("tbl_result", last_result, t_exp[i]);
        end

        // Backpressure: response held 5 cycles with a competing request.
        rsp_ready = 1'b0;
        send_cmd(3'b000, 32'd100, 32'd23, '0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("bp_rsp_valid", rsp_valid, 1);
        hs_before = rsp_count;
        req_op = 3'b001; req_a = 32'd50; req_b = 32'd8; req_shamt = '0; req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("bp_req_ready", req_ready, 0);
            check("bp_result", rsp_result, 32'd123);
        end
        check("bp_no_hs", rsp_count, hs_before);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        n = 0;
        while (rsp_count == hs_before && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("bp_hs_done", rsp_count, hs_before + 1);
        hs_first = hs_cyc;
        run_cmd(3'b001, 32'd50, 32'd8, '0);
        check("bp_second_result", last_result, 32'd42);
        check("bp_accept_cycle", m_acc, hs_first + 1);

        // Abort: reset during the 2nd pass of a 6-pass shift.
        send_cmd(3'b010, 32'd3, 32'd0, 5'd6);
        @(posedge clk);
        #1;
        hs_before = rsp_count;
        reset = 1'b1;
        #1;
        check("abort_alu_en", alu_en, 0);
        check("abort_req_ready", req_ready, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_rsp", rsp_count, hs_before);
        run_cmd(3'b000, 32'd40, 32'd2, '0);
        check("post_abort_add", last_result, 32'd42);
        run_cmd(3'b100, 32'hF000_0000, 32'd0, 5'd4);
        check("post_abort_sra", last_result, 32'hFF00_0000);
        check("post_abort_en_count", last_en_count, 4);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case a wait slips past its bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
